// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: a sync pattern followed by a WIDTH-bit word, MSB first, on line j.
// Define SEQ_FRAME_TX_PARITY_EN to append an even-parity bit after the data word.
module seq_frame_tx #(
  parameter int                 WIDTH   = 8,
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             j,
  output logic             busy,
  output logic             done
);

  localparam int MAXW = (WIDTH > PAT_LEN) ? WIDTH : PAT_LEN;
  localparam int CW   = $clog2(MAXW + 1);

  localparam logic [CW-1:0] ZERO     = '0;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] PAT_LAST = CW'(PAT_LEN - 1);
  localparam logic [CW-1:0] DAT_LAST = CW'(WIDTH - 1);

`ifdef SEQ_FRAME_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SYNC, DATA, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;
`endif

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   din_q;
  logic [PAT_LEN-1:0] pat_q;
`ifdef SEQ_FRAME_TX_PARITY_EN
  logic               par_q;

  function automatic logic even_par(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction
`endif

  // cnt holds the remaining bits of the current field still to follow the one on j;
  // pat_q/din_q are pre-shifted so their MSB is always the next bit to send.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      j     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      din_q <= '0;
      pat_q <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          j <= 1'b0;
          if (start) begin
            din_q <= din;
            pat_q <= PATTERN << 1;
            j     <= PATTERN[PAT_LEN-1];
            busy  <= 1'b1;
            cnt   <= PAT_LAST;
            state <= SYNC;
`ifdef SEQ_FRAME_TX_PARITY_EN
            par_q <= even_par(din);
`endif
          end
        end
        SYNC: begin
          if (cnt == ZERO) begin
            j     <= din_q[WIDTH-1];
            din_q <= din_q << 1;
            cnt   <= DAT_LAST;
            state <= DATA;
          end else begin
            j     <= pat_q[PAT_LEN-1];
            pat_q <= pat_q << 1;
            cnt   <= cnt - ONE;
          end
        end
        DATA: begin
          if (cnt == ZERO) begin
`ifdef SEQ_FRAME_TX_PARITY_EN
            j     <= par_q;
            state <= PAR;
`else
            j     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
`endif
          end else begin
            j     <= din_q[WIDTH-1];
            din_q <= din_q << 1;
            cnt   <= cnt - ONE;
          end
        end
`ifdef SEQ_FRAME_TX_PARITY_EN
        PAR: begin
          j     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
`endif
        default: begin
          j     <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: table vectors, random frames against a
// bit-list reference model, reset, back-to-back and WIDTH=1 corner cases.
module tb_seq_frame_tx;

`ifdef SEQ_FRAME_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int           N       = 5 + 8 + PAR;
  localparam logic [4:0]   PATBITS = 5'b10010;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din   = '0;
  logic       j, busy, done;

  logic       start1 = 1'b0;
  logic [0:0] din1   = '0;
  logic       j1, busy1, done1;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  seq_frame_tx dut (
    .Clock(Clock), .Reset(Reset), .start(start), .din(din),
    .j(j), .busy(busy), .done(done)
  );

  seq_frame_tx #(.WIDTH(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .start(start1), .din(din1),
    .j(j1), .busy(busy1), .done(done1)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0]  din;
    logic [12:0] base;
    bit          par;
    bit          noise;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: pattern MSB first, then data MSB first, then even parity if enabled.
  task automatic build_exp(input logic [7:0] v);
    logic [4:0] p;
    int ones;
    p = PATBITS;
    ones = 0;
    exp_q.delete();
    for (int k = 4; k >= 0; k--) exp_q.push_back(p[k]);
    for (int k = 7; k >= 0; k--) begin
      exp_q.push_back(v[k]);
      ones += int'(v[k]);
    end
    if (PAR == 1) exp_q.push_back((ones % 2) == 1);
  endtask

  // Called at a negedge with the DUT idle; exp_q must already hold the frame.
  task automatic run_frame(input logic [7:0] v, input bit noise);
    start = 1'b1;
    din   = v;
    @(negedge Clock);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("j_bit%0d", i), 32'(j), 32'(exp_q[i]));
      chk("busy_in_frame", 32'(busy), 32'd1);
      chk("done_in_frame", 32'(done), 32'd0);
      if (noise && i < N - 1) begin
        start = 1'($urandom);
        din   = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge Clock);
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("j_end", 32'(j), 32'd0);
    @(negedge Clock);
    chk("done_single", 32'(done), 32'd0);
    chk("j_idle", 32'(j), 32'd0);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'hA5, 13'b10010_10100101, 1'b0, 1'b0};
    tbl[1] = '{8'hFF, 13'b10010_11111111, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 13'b10010_00000000, 1'b0, 1'b1};
    tbl[3] = '{8'h3C, 13'b10010_00111100, 1'b0, 1'b1};
    tbl[4] = '{8'h01, 13'b10010_00000001, 1'b1, 1'b0};
    tbl[5] = '{8'h80, 13'b10010_10000000, 1'b1, 1'b1};

    // Reset state
    #2;
    chk("rst_j", 32'(j), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    // Table vectors with hand-derived frames
    foreach (tbl[t]) begin
      exp_q.delete();
      for (int k = 12; k >= 0; k--) exp_q.push_back(tbl[t].base[k]);
      if (PAR == 1) exp_q.push_back(tbl[t].par);
      run_frame(tbl[t].din, tbl[t].noise);
    end

    // Random frames with random start/din noise while busy
    for (int r = 0; r < 8; r++) begin
      logic [7:0] v;
      v = 8'($urandom);
      build_exp(v);
      repeat ($urandom_range(0, 2)) @(negedge Clock);
      run_frame(v, 1'b1);
    end

    // Reset in idle
    #2 Reset = 1'b1;
    #1;
    chk("idle_rst_j", 32'(j), 32'd0);
    chk("idle_rst_busy", 32'(busy), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    // Reset mid-DATA: j is 1 there with din=FF, so the async clear is visible
    start = 1'b1;
    din   = 8'hFF;
    @(negedge Clock);
    start = 1'b0;
    repeat (7) @(negedge Clock);
    chk("pre_rst_j", 32'(j), 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("data_rst_j", 32'(j), 32'd0);
    chk("data_rst_busy", 32'(busy), 32'd0);
    chk("data_rst_done", 32'(done), 32'd0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge Clock);
      chk("no_done_after_rst", 32'({done, busy, j}), 32'd0);
    end
    build_exp(8'hA5);
    run_frame(8'hA5, 1'b0);

    // start held high: back-to-back frames, one idle 0 between them
    build_exp(8'h00);
    start = 1'b1;
    din   = 8'h00;
    @(negedge Clock);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("b2b_f%0d_bit%0d", f, i), 32'({busy, done, j}), 32'({1'b1, 1'b0, exp_q[i]}));
        @(negedge Clock);
      end
      chk($sformatf("b2b_gap%0d", f), 32'({busy, done, j}), 32'({1'b0, 1'b1, 1'b0}));
      if (f == 2) start = 1'b0;
      @(negedge Clock);
    end
    chk("b2b_stop", 32'({busy, done, j}), 32'd0);

    // WIDTH=1 instance
    start1 = 1'b1;
    din1   = 1'b1;
    @(negedge Clock);
    start1 = 1'b0;
    din1   = 1'b0;
    begin
      bit w1[$];
      w1 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      if (PAR == 1) w1.push_back(1'b1);
      foreach (w1[i]) begin
        chk($sformatf("w1_bit%0d", i), 32'({busy1, done1, j1}), 32'({1'b1, 1'b0, w1[i]}));
        @(negedge Clock);
      end
    end
    chk("w1_done", 32'({busy1, done1, j1}), 32'({1'b0, 1'b1, 1'b0}));
    @(negedge Clock);
    chk("w1_idle", 32'({busy1, done1, j1}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
